// File: rtl/rx_cpl_host_mem.sv
// Receive-side completion engine: accepts CplD TLPs from the 64-bit TRN RX stream,
// realigns the 3DW-header payload back to qwords and writes it into a tag-indexed chunk buffer.
module rx_cpl_host_mem #(
  parameter int TAG_BITS = 2
) (
  input  logic                trn_clk,
  input  logic                reset_n,
  input  logic [63:0]         trn_rd,
  input  logic [7:0]          trn_rrem_n,
  input  logic                trn_rsof_n,
  input  logic                trn_reof_n,
  input  logic                trn_rsrc_rdy_n,
  output logic                trn_rdst_rdy_n,
  output logic                buf_wr_en,
  output logic [TAG_BITS+5:0] buf_wr_addr,
  output logic [63:0]         buf_wr_data,
  output logic                chunk_done,
  output logic [TAG_BITS-1:0] chunk_done_tag,
  output logic                cpl_err
);
  localparam int         NTAG = 1 << TAG_BITS;
  localparam logic [6:0] CPLD = 7'b1001010;

  typedef enum logic [1:0] {IDLE = 2'd0, HDR1 = 2'd1, DATA = 2'd2, SKIP = 2'd3} state_t;

  state_t              state_r, state_s, new_tlp_s;
  logic                rdst_rdy_n_r;
  logic                ep_r;
  logic [9:0]          length_r;
  logic [2:0]          status_r;
  logic [11:0]         byte_count_r;
  logic [TAG_BITS-1:0] tag_r;
  logic [31:0]         carry_r;
  logic [6:0]          cnt_r;
  logic [5:0]          offset_r [NTAG];
  logic                buf_wr_en_r, chunk_done_r, cpl_err_r;
  logic [TAG_BITS+5:0] buf_wr_addr_r;
  logic [63:0]         buf_wr_data_r;
  logic [TAG_BITS-1:0] chunk_done_tag_r;
  logic                accept_s, sof_s, eof_s, hdr_err_s, complete_s, last_s;
  logic                wr_s, err_s, done_s;

  assign accept_s   = !trn_rsrc_rdy_n && !rdst_rdy_n_r;
  assign sof_s      = accept_s && !trn_rsof_n;
  assign eof_s      = accept_s && !trn_reof_n;
  // A single-beat TLP never leaves IDLE; otherwise CplD goes to HDR1, anything else is skipped.
  assign new_tlp_s  = !trn_reof_n ? IDLE : ((trn_rd[62:56] == CPLD) ? HDR1 : SKIP);
  assign hdr_err_s  = (status_r != 3'd0) || ep_r || length_r[0] || (length_r == 10'd0) ||
                      (length_r > 10'd128) || ((trn_rd[47:40] >> TAG_BITS) != 8'd0);
  assign complete_s = (cnt_r + 7'd1) == length_r[7:1];
  assign last_s     = byte_count_r == {length_r, 2'b00};

  // State register.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Next-state logic; a stray sof restarts parsing on the same beat.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (sof_s) state_s = new_tlp_s;
        else       state_s = IDLE;
      end
      HDR1: begin
        if (sof_s)         state_s = new_tlp_s;
        else if (eof_s)    state_s = IDLE;
        else if (accept_s) state_s = hdr_err_s ? SKIP : DATA;
        else               state_s = HDR1;
      end
      DATA: begin
        if (sof_s)      state_s = new_tlp_s;
        else if (eof_s) state_s = IDLE;
        else            state_s = DATA;
      end
      SKIP: begin
        if (eof_s) state_s = IDLE;
        else       state_s = SKIP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode: writes, error and completion pulses for the beat being accepted.
  always_comb begin
    wr_s   = 1'b0;
    err_s  = 1'b0;
    done_s = 1'b0;
    case (state_r)
      HDR1: begin
        if (sof_s)         err_s = 1'b1;
        else if (accept_s) err_s = eof_s || hdr_err_s;
        else               err_s = 1'b0;
      end
      DATA: begin
        if (sof_s) begin
          err_s = 1'b1;
        end else if (accept_s) begin
          wr_s   = 1'b1;
          err_s  = eof_s && !complete_s;
          done_s = eof_s && complete_s && last_s;
        end else begin
          wr_s = 1'b0;
        end
      end
      default: err_s = 1'b0;
    endcase
  end

  // Header capture, realignment datapath, per-tag offsets and registered outputs.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      rdst_rdy_n_r     <= 1'b1;
      ep_r             <= 1'b0;
      length_r         <= 10'd0;
      status_r         <= 3'd0;
      byte_count_r     <= 12'd0;
      tag_r            <= '0;
      carry_r          <= 32'd0;
      cnt_r            <= 7'd0;
      for (int i = 0; i < NTAG; i++) offset_r[i] <= 6'd0;
      buf_wr_en_r      <= 1'b0;
      buf_wr_addr_r    <= '0;
      buf_wr_data_r    <= 64'd0;
      chunk_done_r     <= 1'b0;
      chunk_done_tag_r <= '0;
      cpl_err_r        <= 1'b0;
    end else begin
      rdst_rdy_n_r <= 1'b0;
      if (sof_s) begin
        ep_r         <= trn_rd[46];
        length_r     <= trn_rd[41:32];
        status_r     <= trn_rd[15:13];
        byte_count_r <= trn_rd[11:0];
      end
      if (state_r == HDR1 && accept_s && !sof_s) begin
        tag_r   <= trn_rd[40 +: TAG_BITS];
        carry_r <= trn_rd[31:0];
        cnt_r   <= 7'd0;
      end
      if (wr_s) begin
        cnt_r <= cnt_r + 7'd1;
        // The lower DW of the final beat is padding and never becomes carry.
        if (trn_rrem_n == 8'h00) carry_r <= trn_rd[31:0];
        offset_r[tag_r] <= done_s ? 6'd0 : offset_r[tag_r] + 6'd1;
        buf_wr_addr_r   <= {tag_r, offset_r[tag_r]};
        buf_wr_data_r   <= {carry_r, trn_rd[63:32]};
      end
      buf_wr_en_r  <= wr_s;
      chunk_done_r <= done_s;
      if (done_s) chunk_done_tag_r <= tag_r;
      cpl_err_r    <= err_s;
    end
  end

  assign trn_rdst_rdy_n = rdst_rdy_n_r;
  assign buf_wr_en      = buf_wr_en_r;
  assign buf_wr_addr    = buf_wr_addr_r;
  assign buf_wr_data    = buf_wr_data_r;
  assign chunk_done     = chunk_done_r;
  assign chunk_done_tag = chunk_done_tag_r;
  assign cpl_err        = cpl_err_r;
endmodule
